// File: rtl/uart_pkg.sv
// Shared UART definitions: default character width and the receive-entry layout
// used by the receive buffer and the bus register block.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef struct packed {
    logic [UART_DATA_BITS-1:0] data;
    logic                      parity_err;
    logic                      frame_err;
  } rx_entry_t;

  localparam int unsigned RX_ENTRY_BITS = $bits(rx_entry_t);

endpackage

// File: rtl/sync_fifo_mem.sv
// Width x depth register array: synchronous write port, asynchronous read port.
module sync_fifo_mem #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures bytes plus error flags on data_ready and presents
// them FWFT on a valid/ready port, with sticky overrun and level interrupt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = UART_DATA_BITS,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned IRQ_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_BITS-1:0]       rx_data,
  input  logic                       data_ready,
  input  logic                       parity_err,
  input  logic                       frame_err,
  output logic [DATA_BITS-1:0]       m_data,
  output logic                       m_parity_err,
  output logic                       m_frame_err,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       overrun,
  input  logic                       err_clear,
  output logic                       irq
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);
  localparam int unsigned EW = DATA_BITS + 2;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic          overrun_q;
  logic          push;
  logic          pop;
  logic          drop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  assign m_valid = (level_q != '0);
  assign full    = (level_q == LW'(DEPTH));
  assign pop     = m_valid & m_ready;
  // A full buffer still accepts a byte when the head leaves in the same cycle.
  assign push    = data_ready & (~full | pop);
  assign drop    = data_ready & full & ~pop;

  assign wr_entry = {rx_data, parity_err, frame_err};

  sync_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign m_data       = rd_entry[EW-1:2];
  assign m_parity_err = rd_entry[1];
  assign m_frame_err  = rd_entry[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push & ~pop)      level_q <= level_q + LW'(1);
      else if (pop & ~push) level_q <= level_q - LW'(1);
      if (drop)           overrun_q <= 1'b1;
      else if (err_clear) overrun_q <= 1'b0;
    end
  end

  assign level   = level_q;
  assign overrun = overrun_q;
  assign irq     = (level_q >= LW'(IRQ_LEVEL)) | overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, IRQ_LEVEL=1).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;
  logic [7:0] m_data;
  logic       m_parity_err;
  logic       m_frame_err;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] level;
  logic       full;
  logic       overrun;
  logic       err_clear;
  logic       irq;

  int errors = 0;
  int checks = 0;

  uart_rx_fifo #(
    .DATA_BITS (8),
    .DEPTH     (16),
    .IRQ_LEVEL (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .m_data       (m_data),
    .m_parity_err (m_parity_err),
    .m_frame_err  (m_frame_err),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .level        (level),
    .full         (full),
    .overrun      (overrun),
    .err_clear    (err_clear),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs from the falling edge, then settle just after the rising edge.
  task automatic cyc(input logic rst, input logic dr, input logic [7:0] d,
                     input logic pe, input logic fe, input logic rdy, input logic clr);
    @(negedge clk);
    reset      = rst;
    data_ready = dr;
    rx_data    = d;
    parity_err = pe;
    frame_err  = fe;
    m_ready    = rdy;
    err_clear  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    cyc(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, m_data}, {24'd0, exp});
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; data_ready = 1'b0; rx_data = 8'h00; parity_err = 1'b0;
    frame_err = 1'b0; m_ready = 1'b0; err_clear = 1'b0;
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);

    // Fill/drain
    push(8'h00);
    chk("fill_first_valid", {31'd0, m_valid}, 32'd1);
    chk("fill_first_data", {24'd0, m_data}, 32'h00);
    chk("fill_first_irq", {31'd0, irq}, 32'd1);
    for (int i = 1; i < 16; i++) push(8'(i));
    chk("fill_level", {27'd0, level}, 32'd16);
    chk("fill_full", {31'd0, full}, 32'd1);
    for (int i = 0; i < 16; i++) pop_check("drain", 8'(i));
    chk("drain_valid", {31'd0, m_valid}, 32'd0);
    chk("drain_level", {27'd0, level}, 32'd0);
    chk("drain_irq", {31'd0, irq}, 32'd0);

    // Overrun
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    push(8'hA5);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    chk("ovr_irq", {31'd0, irq}, 32'd1);
    chk("ovr_level", {27'd0, level}, 32'd16);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clear", {31'd0, overrun}, 32'd0);
    cyc(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_set_wins", {31'd0, overrun}, 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clear2", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 16; i++) pop_check("ovr_drain", 8'h10 + 8'(i));
    chk("ovr_no_a5", {31'd0, m_valid}, 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    chk("fpp_full", {31'd0, full}, 32'd1);
    chk("fpp_head", {24'd0, m_data}, 32'h20);
    cyc(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fpp_level", {27'd0, level}, 32'd16);
    chk("fpp_overrun", {31'd0, overrun}, 32'd0);
    for (int i = 1; i < 16; i++) pop_check("fpp_drain", 8'h20 + 8'(i));
    pop_check("fpp_3c", 8'h3C);
    chk("fpp_empty", {31'd0, m_valid}, 32'd0);

    // Error flag propagation
    cyc(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("err_pe0", {31'd0, m_parity_err}, 32'd1);
    chk("err_fe0", {31'd0, m_frame_err}, 32'd0);
    pop_check("err_55", 8'h55);
    chk("err_pe1", {31'd0, m_parity_err}, 32'd0);
    chk("err_fe1", {31'd0, m_frame_err}, 32'd1);
    pop_check("err_66", 8'h66);
    chk("err_level", {27'd0, level}, 32'd0);

    // Wrap and throughput: level stays 1, each byte visible the cycle after its push
    push(8'h80);
    for (int i = 1; i < 40; i++) begin
      chk("thr_level", {27'd0, level}, 32'd1);
      chk("thr_data", {24'd0, m_data}, {24'd0, 8'h80 + 8'(i - 1)});
      cyc(1'b0, 1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
    end
    pop_check("thr_last", 8'hA7);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("empty_rdy_level", {27'd0, level}, 32'd0);
    chk("empty_rdy_valid", {31'd0, m_valid}, 32'd0);
    push(8'h99);
    chk("empty_rdy_head", {24'd0, m_data}, 32'h99);

    // Reset mid-operation
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    chk("mid_level", {27'd0, level}, 32'd5);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_level", {27'd0, level}, 32'd0);
    chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    push(8'h12);
    pop_check("mid_12", 8'h12);
    chk("mid_empty", {31'd0, m_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It captures each received byte and its per-byte parity and framing error flags when the receiver pulses `data_ready`. It holds up to `DEPTH` entries and presents them to the host/bus side through a first-word-fall-through valid/ready interface. It also flags overrun when a byte arrives while the buffer is full, and raises a level-threshold interrupt.

## Interface
- `DATA_BITS`, 8, width of a received character; must match the receiver.
- `DEPTH`, 16, number of entries; power of two, ≥2.
- `IRQ_LEVEL`, 1, `irq` asserts when `level` ≥ this value; range 1..`DEPTH`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `rx_data`  in  `DATA_BITS`  byte from receiver; valid only in the `data_ready` cycle.
- `data_ready`  in  1  one-cycle pulse per received byte.
- `parity_err`  in  1  parity error for the byte presented with `data_ready`.
- `frame_err`  in  1  stop-bit error for the byte presented with `data_ready`.
- `m_data`  out  `DATA_BITS`  head-entry byte.
- `m_parity_err`  out  1  head-entry parity flag.
- `m_frame_err`  out  1  head-entry framing flag.
- `m_valid`  out  1  head entry present (not empty).
- `m_ready`  in  1  consumer accepts the head entry.
- `level`  out  `$clog2(DEPTH+1)`  occupied entries, 0..`DEPTH`.
- `full`  out  1  `level == DEPTH`.
- `overrun`  out  1  sticky; a byte was dropped.
- `err_clear`  in  1  clears `overrun`.
- `irq`  out  1  `(level >= IRQ_LEVEL) | overrun`.

## Operation
- Each entry is {data, parity_err, frame_err}, `DATA_BITS+2` bits. The error flags are captured verbatim from the receiver in the same cycle as the data.
- **push** = `data_ready`, accepted when `!full` or when a pop occurs in the same cycle.
- **pop** = `m_valid & m_ready`.
- Accepted push: write the entry at `wr_ptr`, then `wr_ptr` increments.
- Pop: `rd_ptr` increments.
- Pointer width is `$clog2(DEPTH)`. Pointers wrap naturally from `DEPTH-1` to 0.
- `level` update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Never exceeds `DEPTH` and never goes below 0.
- Push while full with no pop: the byte is dropped, storage is unchanged, and `overrun` is set.
- `err_clear`:
  - Clears `overrun` on the next edge.
  - If a drop occurs in the same cycle, set wins and `overrun` stays 1.
- Push while empty with no pop: a normal write. There is no bypass path.
- `m_ready` while empty has no effect. Pointers do not move.
- Reset values:
  - `wr_ptr`, `rd_ptr`, `level`: 0.
  - `overrun`: 0.
  - Outputs: `m_valid`=0, `full`=0, `irq`=0.
  - Storage contents are not cleared. `m_data`, `m_parity_err` and `m_frame_err` are don't-care while `m_valid`=0.
- Reset mid-operation discards all stored entries.

## Timing
- All state is registered on posedge `clk`.
- `m_valid`, `full`, `level` and `irq` are decoded from registered state, with no combinational path from any input.
- `m_data`, `m_parity_err` and `m_frame_err` are a combinational read of the storage array at `rd_ptr` (FWFT).
- Push-to-visible latency is 1 cycle. A push on edge N gives `m_valid`=1 and valid head data in the cycle after edge N.
- A pop on edge N presents the next entry, or `m_valid`=0, in the cycle after edge N.
- Sustained throughput is one push and one pop per cycle.
- `m_data` must stay stable while `m_valid & !m_ready`.

## Structure
- Shared package `uart_pkg`:
  - Default `DATA_BITS` constant.
  - `rx_entry_t` packed struct {data, parity_err, frame_err}, used by this block and by the bus register block.
- One natural sub-module: `sync_fifo_mem`, a parameterized width×depth register array with a synchronous write port and an asynchronous read port.
- Pointers, level, overrun and irq logic live in `uart_rx_fifo`.

## Test plan
- **Fill/drain, DEPTH=16:** push 0x00..0x0F with `m_ready`=0.
  - `level`=16, `full`=1.
  - Then `m_ready`=1: reads 0x00..0x0F in order, `m_valid` drops after the 16th pop, `level`=0.
- **Overrun:** fill to 16, push 0xA5.
  - `overrun`=1, `irq`=1, `level`=16, and 0xA5 is never read.
  - `err_clear` → `overrun`=0.
  - Simultaneous drop + `err_clear` → `overrun` stays 1.
- **Full with simultaneous push/pop:** full, `m_ready`=1, push 0x3C.
  - Head pops, 0x3C is accepted, `level` stays 16, `overrun` stays 0.
  - 0x3C is read as the 16th subsequent entry.
- **Error flag propagation:**
  - Push 0x55 with `parity_err`=1, then 0x66 with `frame_err`=1.
  - Head shows 0x55/p=1/f=0, then 0x66/p=0/f=1.
- **Wrap and throughput:** stream 40 bytes with push and pop every cycle after the first.
  - `level` stays 1, output order is preserved across pointer wrap, and each byte is visible one cycle after its push.
- **Reset mid-operation:** `level`=5, assert `reset` one cycle.
  - `level`=0, `m_valid`=0, `overrun`=0, `irq`=0.
  - The next push of 0x12 is the next byte read.
